// File: rtl/y86_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state
// encoding, default memory size, status codes and the address range check.
package y86_mem_pkg;

   localparam int MEM_BYTES_DEFAULT = 1024;

   // Status codes shared with the rest of the Y86 pipeline.
   localparam logic [3:0] STAT_AOK = 4'b1000;
   localparam logic [3:0] STAT_ADR = 4'b0010;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      D_ACC   = 3'd1,
      F_BEAT0 = 3'd2,
      F_BEAT1 = 3'd3,
      RESP    = 3'd4
   } arb_state_e;

   // True when the last byte of an access (addr + span) lies at or below
   // last_byte. Done in 65 bits so an address near 2^64 cannot wrap into range.
   function automatic logic in_range(input logic [63:0] addr,
                                     input logic [64:0] span,
                                     input logic [64:0] last_byte);
      return (({1'b0, addr} + span) <= last_byte);
   endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Per-beat wait counter: counts cycles spent waiting for a memory
// acknowledge and flags when the wait limit has been used up.
module arb_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = ($clog2(LIMIT + 1) < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_r;

   // Wait-cycle count; clear wins over enable, and the count parks at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (enable && (cnt_r != CW'(LIMIT - 1))) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // The current cycle is the last one allowed without an acknowledge.
   assign expired = (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port (10-byte instruction, two memory beats) and a
// data port (one 8-byte beat) onto a single memory interface, with
// starvation protection for fetch, range checking and per-beat timeout.
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   output logic        f_done,
   output logic [79:0] f_instr,
   output logic        f_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_done,
   output logic [63:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   localparam int SW = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [64:0] MEM_LAST = 65'(MEM_BYTES) - 65'd1;

   arb_state_e    state_r;
   arb_state_e    state_next;
   logic [SW-1:0] starve_r;
   logic          is_fetch_r;
   logic [63:0]   beat0_r;

   logic f_ok_s;
   logic d_ok_s;
   logic take_d_s;
   logic take_f_s;
   logic fin_s;
   logic fin_err_s;
   logic fin_fetch_s;
   logic in_beat_s;
   logic expired_s;

   assign f_ok_s    = in_range(f_addr, 65'd9, MEM_LAST);
   assign d_ok_s    = in_range(d_addr, 65'd7, MEM_LAST);
   assign in_beat_s = (state_r == D_ACC) || (state_r == F_BEAT0) || (state_r == F_BEAT1);

   arb_timeout_ctr #(
      .LIMIT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!in_beat_s || mem_ack),
      .enable (in_beat_s && !mem_ack),
      .expired(expired_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next state, arbitration decision and completion events.
   always_comb begin
      state_next  = state_r;
      take_d_s    = 1'b0;
      take_f_s    = 1'b0;
      fin_s       = 1'b0;
      fin_err_s   = 1'b0;
      fin_fetch_s = is_fetch_r;
      case (state_r)
         IDLE: begin
            if (d_req && (!f_req || (starve_r != SW'(STARVE_MAX)))) begin
               take_d_s    = 1'b1;
               fin_fetch_s = 1'b0;
               if (d_ok_s) begin
                  state_next = D_ACC;
               end else begin
                  state_next = RESP;
                  fin_s      = 1'b1;
                  fin_err_s  = 1'b1;
               end
            end else if (f_req) begin
               take_f_s    = 1'b1;
               fin_fetch_s = 1'b1;
               if (f_ok_s) begin
                  state_next = F_BEAT0;
               end else begin
                  state_next = RESP;
                  fin_s      = 1'b1;
                  fin_err_s  = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         D_ACC, F_BEAT1: begin
            if (mem_ack) begin
               state_next = RESP;
               fin_s      = 1'b1;
            end else if (expired_s) begin
               state_next = RESP;
               fin_s      = 1'b1;
               fin_err_s  = 1'b1;
            end else begin
               state_next = state_r;
            end
         end
         F_BEAT0: begin
            if (mem_ack) begin
               state_next = F_BEAT1;
            end else if (expired_s) begin
               state_next = RESP;
               fin_s      = 1'b1;
               fin_err_s  = 1'b1;
            end else begin
               state_next = F_BEAT0;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Starvation counter and record of which requester owns the transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_r   <= '0;
         is_fetch_r <= 1'b0;
      end else if (take_f_s) begin
         starve_r   <= '0;
         is_fetch_r <= 1'b1;
      end else if (take_d_s) begin
         is_fetch_r <= 1'b0;
         if (f_req && (starve_r != SW'(STARVE_MAX))) begin
            starve_r <= starve_r + SW'(1);
         end else begin
            starve_r <= starve_r;
         end
      end else begin
         starve_r   <= starve_r;
         is_fetch_r <= is_fetch_r;
      end
   end

   // Memory port: fields are captured at grant and held until the access ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 64'd0;
         mem_wdata <= 64'd0;
      end else if (take_d_s && d_ok_s) begin
         mem_req   <= 1'b1;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
      end else if (take_f_s && f_ok_s) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= f_addr;
         mem_wdata <= 64'd0;
      end else if ((state_r == F_BEAT0) && mem_ack) begin
         mem_addr  <= mem_addr + 64'd8;
      end else if (fin_s) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 64'd0;
         mem_wdata <= 64'd0;
      end else begin
         mem_req   <= mem_req;
      end
   end

   // First fetch beat is kept until the second beat completes the instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat0_r <= 64'd0;
      end else if ((state_r == F_BEAT0) && mem_ack) begin
         beat0_r <= mem_rdata;
      end else begin
         beat0_r <= beat0_r;
      end
   end

   // Completion pulses and response data; data is held until the next
   // completion of the same requester and forced to zero on error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_done  <= 1'b0;
         f_err   <= 1'b0;
         f_instr <= 80'd0;
         d_done  <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= 64'd0;
      end else begin
         f_done <= 1'b0;
         f_err  <= 1'b0;
         d_done <= 1'b0;
         d_err  <= 1'b0;
         if (fin_s && fin_fetch_s) begin
            f_done  <= 1'b1;
            f_err   <= fin_err_s;
            f_instr <= fin_err_s ? 80'd0 : {beat0_r, mem_rdata[63:48]};
         end else if (fin_s) begin
            d_done  <= 1'b1;
            d_err   <= fin_err_s;
            d_rdata <= fin_err_s ? 64'd0 : mem_rdata;
         end else begin
            f_instr <= f_instr;
            d_rdata <= d_rdata;
         end
      end
   end

   // Busy mirrors "not IDLE" for the cycle the state register will hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory responder.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req;
   logic [63:0] f_addr;
   logic        f_done;
   logic [79:0] f_instr;
   logic        f_err;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_done;
   logic [63:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;
   logic        busy;

   mem_port_arbiter #(
      .MEM_BYTES (1024),
      .STARVE_MAX(4),
      .TIMEOUT   (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_done   (f_done),
      .f_instr  (f_instr),
      .f_err    (f_err),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_done   (d_done),
      .d_rdata  (d_rdata),
      .d_err    (d_err),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:1023];
   int  wait_cycles = 0;
   bit  withhold    = 1'b0;
   bit  late_ack    = 1'b0;
   int  wcnt        = 0;
   int  n_checks    = 0;
   int  n_fail      = 0;

   task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rd_word(input logic [63:0] a);
      logic [63:0] w;
      logic [63:0] b;
      w = 64'd0;
      for (int i = 0; i < 8; i++) begin
         b = a + 64'(i);
         w = w << 8;
         if (b < 64'd1024) w[7:0] = mem[b[9:0]];
      end
      return w;
   endfunction

   task automatic wr_word(input logic [63:0] a, input logic [63:0] w);
      logic [63:0] b;
      for (int i = 0; i < 8; i++) begin
         b = a + 64'(i);
         if (b < 64'd1024) mem[b[9:0]] = w[63-8*i -: 8];
      end
   endtask

   // Memory responder: acknowledges after wait_cycles of held mem_req.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 64'd0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 64'd0;
         if (late_ack) begin
            mem_ack = 1'b1;
         end else if (mem_req && !withhold) begin
            if (wcnt >= wait_cycles) begin
               mem_ack   = 1'b1;
               mem_rdata = rd_word(mem_addr);
               if (mem_we) wr_word(mem_addr, mem_wdata);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      logic [9:0] got_order;
      logic [9:0] exp_order;
      int         ndone;
      int         cyc;
      bit         saw_bad;

      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      rst_n = 1'b0; f_req = 1'b0; f_addr = 64'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
      repeat (2) @(negedge clk);
      check_val("rst_busy",    busy,    1'b0);
      check_val("rst_mem_req", mem_req, 1'b0);
      check_val("rst_f_done",  f_done,  1'b0);
      check_val("rst_d_done",  d_done,  1'b0);
      check_val("rst_f_instr", f_instr, 80'd0);
      check_val("rst_d_rdata", d_rdata, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Data read at 16, zero-wait
      d_we = 1'b0; d_addr = 64'd16; d_req = 1'b1;
      @(negedge clk);
      check_val("rd_c1_mem_req",  mem_req,  1'b1);
      check_val("rd_c1_mem_addr", mem_addr, 64'd16);
      check_val("rd_c1_mem_we",   mem_we,   1'b0);
      check_val("rd_c1_no_done",  d_done,   1'b0);
      @(negedge clk);
      check_val("rd_c2_done",  d_done,  1'b1);
      check_val("rd_c2_err",   d_err,   1'b0);
      check_val("rd_c2_rdata", d_rdata, 64'h1011121314151617);
      d_req = 1'b0;
      @(negedge clk);
      check_val("rd_c3_pulse", d_done, 1'b0);
      check_val("rd_c3_busy",  busy,   1'b0);

      // Fetch at 14 with bytes 40 24 00 ...
      mem[14] = 8'h40; mem[15] = 8'h24;
      for (int i = 16; i < 24; i++) mem[i] = 8'h00;
      f_addr = 64'd14; f_req = 1'b1;
      @(negedge clk);
      check_val("f14_c1_addr", mem_addr, 64'd14);
      check_val("f14_c1_we",   mem_we,   1'b0);
      @(negedge clk);
      check_val("f14_c2_addr", mem_addr, 64'd22);
      check_val("f14_c2_done", f_done,   1'b0);
      @(negedge clk);
      check_val("f14_c3_done",  f_done,  1'b1);
      check_val("f14_c3_err",   f_err,   1'b0);
      check_val("f14_c3_instr", f_instr, 80'h4024_0000_0000_0000_0000);
      check_val("d_rdata_hold", d_rdata, 64'h1011121314151617);
      f_req = 1'b0;
      @(negedge clk);

      // Fetch at 1014: last in-range fetch
      f_addr = 64'd1014; f_req = 1'b1;
      @(negedge clk);
      check_val("f1014_req", mem_req, 1'b1);
      repeat (2) @(negedge clk);
      check_val("f1014_done",  f_done,  1'b1);
      check_val("f1014_err",   f_err,   1'b0);
      check_val("f1014_instr", f_instr, 80'hF6F7_F8F9_FAFB_FCFD_FEFF);
      f_req = 1'b0;
      @(negedge clk);

      // Fetch at 1015: out of range, immediate error
      f_addr = 64'd1015; f_req = 1'b1;
      @(negedge clk);
      check_val("f1015_done",  f_done,  1'b1);
      check_val("f1015_err",   f_err,   1'b1);
      check_val("f1015_noreq", mem_req, 1'b0);
      check_val("f1015_instr", f_instr, 80'd0);
      f_req = 1'b0;
      @(negedge clk);
      check_val("f1015_idle", busy, 1'b0);

      // Data at 1017 out of range, 1016 in range
      d_we = 1'b0; d_addr = 64'd1017; d_req = 1'b1;
      @(negedge clk);
      check_val("d1017_done",  d_done,  1'b1);
      check_val("d1017_err",   d_err,   1'b1);
      check_val("d1017_rdata", d_rdata, 64'd0);
      d_req = 1'b0;
      @(negedge clk);
      d_addr = 64'd1016; d_req = 1'b1;
      @(negedge clk);
      check_val("d1016_req", mem_req, 1'b1);
      @(negedge clk);
      check_val("d1016_err",   d_err,   1'b0);
      check_val("d1016_rdata", d_rdata, 64'hF8F9_FAFB_FCFD_FEFF);
      d_req = 1'b0;
      @(negedge clk);

      // Write at 32, then read back
      d_we = 1'b1; d_addr = 64'd32; d_wdata = 64'hDEAD_BEEF_0123_4567; d_req = 1'b1;
      @(negedge clk);
      check_val("wr_we",    mem_we,    1'b1);
      check_val("wr_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
      @(negedge clk);
      check_val("wr_done", d_done, 1'b1);
      d_req = 1'b0;
      @(negedge clk);
      d_we = 1'b0; d_req = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rb_rdata", d_rdata, 64'hDEAD_BEEF_0123_4567);
      d_req = 1'b0;
      @(negedge clk);

      // Two wait states on a read at 40
      wait_cycles = 2;
      d_addr = 64'd40; d_req = 1'b1;
      repeat (3) @(negedge clk);
      check_val("ws_c3_done", d_done,  1'b0);
      check_val("ws_c3_req",  mem_req, 1'b1);
      @(negedge clk);
      check_val("ws_c4_done",  d_done,  1'b1);
      check_val("ws_c4_rdata", d_rdata, 64'h2829_2A2B_2C2D_2E2F);
      d_req = 1'b0;
      @(negedge clk);
      wait_cycles = 0;

      // Both requests held: starvation limit forces every fifth grant to fetch
      exp_order = 10'b10_0001_0000;
      got_order = 10'd0;
      ndone = 0; cyc = 0;
      f_addr = 64'd200; d_addr = 64'd300; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      while (ndone < 10 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (f_done) begin
            got_order[ndone] = 1'b1;
            ndone++;
         end else if (d_done) begin
            got_order[ndone] = 1'b0;
            ndone++;
         end
         if (ndone >= 10) begin
            f_req = 1'b0;
            d_req = 1'b0;
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      check_val("order_count", 80'(ndone), 80'd10);
      check_val("order_seq",   got_order,  exp_order);
      repeat (2) @(negedge clk);

      // Timeout: no ack for 16 cycles
      withhold = 1'b1;
      d_addr = 64'd48; d_req = 1'b1;
      saw_bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!mem_req || d_done) saw_bad = 1'b1;
      end
      check_val("to_held_16", saw_bad, 1'b0);
      @(negedge clk);
      check_val("to_done",  d_done,  1'b1);
      check_val("to_err",   d_err,   1'b1);
      check_val("to_rdata", d_rdata, 64'd0);
      check_val("to_noreq", mem_req, 1'b0);
      d_req = 1'b0;
      withhold = 1'b0;
      @(negedge clk);
      late_ack = 1'b1;
      repeat (2) @(negedge clk);
      late_ack = 1'b0;
      @(negedge clk);
      check_val("late_ack_busy", busy,   1'b0);
      check_val("late_ack_done", d_done, 1'b0);

      // Reset in the middle of the second fetch beat
      wait_cycles = 3;
      f_addr = 64'd64; f_req = 1'b1;
      repeat (5) @(negedge clk);
      check_val("rst_mid_addr", mem_addr, 64'd72);
      check_val("rst_mid_req",  mem_req,  1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_async_req",  mem_req, 1'b0);
      check_val("rst_async_busy", busy,    1'b0);
      f_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles = 0;
      saw_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (f_done || busy) saw_bad = 1'b1;
      end
      check_val("rst_no_done", saw_bad, 1'b0);

      // Normal operation after reset
      d_addr = 64'd0; d_we = 1'b0; d_req = 1'b1;
      repeat (2) @(negedge clk);
      check_val("post_rst_done",  d_done,  1'b1);
      check_val("post_rst_rdata", d_rdata, 64'h0001_0203_0405_0607);
      d_req = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
